// File: rtl/fft2d_pkg.sv
// Shared definitions for the 4x4 streaming 2D DFT engine.
//   N           : transform size in each dimension
//   GROWTH_ROW  : bit growth of the row pass (4-point sum -> 2 bits)
//   state_t     : engine control states
//   lane_lo()   : low bit index of lane 'lane' in a packed vector of w-bit lanes
package fft2d_pkg;

    localparam int N          = 4;
    localparam int GROWTH_ROW = 2;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        CALC  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int lane_lo(input int lane, input int w);
        return lane * w;
    endfunction

endpackage

// File: rtl/fft2d_4x4_stream_if.sv
// Row-in / column-out stream bundle of the 4x4 2D DFT engine.
//   master : frame source and result sink (framer / post-processing side)
//   slave  : the engine
// Input lane i of in_re/in_im is column i of the row; output lane k of
// out_re/out_im is X[k][out_col].
interface fft2d_4x4_stream_if #(
    parameter int DATA_W = 16,
    parameter int OUT_W  = DATA_W + 4
);
    logic                  in_valid;
    logic                  in_ready;
    logic [4*DATA_W-1:0]   in_re;
    logic [4*DATA_W-1:0]   in_im;
    logic                  in_inverse;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*OUT_W-1:0]    out_re;
    logic [4*OUT_W-1:0]    out_im;
    logic [1:0]            out_col;
    logic                  out_last;

    modport master (
        output in_valid, in_re, in_im, in_inverse, out_ready,
        input  in_ready, out_valid, out_re, out_im, out_col, out_last
    );

    modport slave (
        input  in_valid, in_re, in_im, in_inverse, out_ready,
        output in_ready, out_valid, out_re, out_im, out_col, out_last
    );
endinterface

// File: rtl/fft4_cplx_kernel.sv
// Combinational complex 4-point DFT kernel (multiplier-free).
//   a_re, a_im : N packed IN_W-bit signed inputs a0..a3
//   inverse    : 0 -> W = e^(-j2pi/4), 1 -> W = e^(+j2pi/4)
//   g_re, g_im : N packed OUT_W-bit signed outputs G0..G3
// Inputs are sign-extended to OUT_W before any arithmetic; OUT_W >= IN_W+2
// keeps every output exact.
module fft4_cplx_kernel
    import fft2d_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = IN_W + 2
) (
    input  logic [N*IN_W-1:0]  a_re,
    input  logic [N*IN_W-1:0]  a_im,
    input  logic               inverse,
    output logic [N*OUT_W-1:0] g_re,
    output logic [N*OUT_W-1:0] g_im
);
    logic signed [OUT_W-1:0] xr [N];
    logic signed [OUT_W-1:0] xi [N];
    logic signed [OUT_W-1:0] gr [N];
    logic signed [OUT_W-1:0] gi [N];
    logic signed [OUT_W-1:0] sum_r, sum_i, dif_r, dif_i;
    logic signed [OUT_W-1:0] odd_sr, odd_si, odd_dr, odd_di;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            xr[i] = {{(OUT_W-IN_W){a_re[lane_lo(i, IN_W)+IN_W-1]}}, a_re[lane_lo(i, IN_W) +: IN_W]};
            xi[i] = {{(OUT_W-IN_W){a_im[lane_lo(i, IN_W)+IN_W-1]}}, a_im[lane_lo(i, IN_W) +: IN_W]};
        end
        sum_r  = xr[0] + xr[2];
        sum_i  = xi[0] + xi[2];
        dif_r  = xr[0] - xr[2];
        dif_i  = xi[0] - xi[2];
        odd_sr = xr[1] + xr[3];
        odd_si = xi[1] + xi[3];
        odd_dr = xr[1] - xr[3];
        odd_di = xi[1] - xi[3];

        gr[0] = sum_r + odd_sr;
        gi[0] = sum_i + odd_si;
        gr[2] = sum_r - odd_sr;
        gi[2] = sum_i - odd_si;
        // j*(dr + j*di) = -di + j*dr: forward G1 = dif - j*odd, G3 = dif + j*odd;
        // inverse mode simply swaps the two.
        if (!inverse) begin
            gr[1] = dif_r + odd_di;
            gi[1] = dif_i - odd_dr;
            gr[3] = dif_r - odd_di;
            gi[3] = dif_i + odd_dr;
        end else begin
            gr[1] = dif_r - odd_di;
            gi[1] = dif_i + odd_dr;
            gr[3] = dif_r + odd_di;
            gi[3] = dif_i - odd_dr;
        end

        g_re = '0;
        g_im = '0;
        for (int i = 0; i < N; i++) begin
            g_re[lane_lo(i, OUT_W) +: OUT_W] = gr[i];
            g_im[lane_lo(i, OUT_W) +: OUT_W] = gi[i];
        end
    end
endmodule

// File: rtl/fft2d_4x4_stream.sv
// Streaming 4x4 2D DFT engine.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : slave side of fft2d_4x4_stream_if (row beats in, column beats out)
// Each accepted row goes through the row kernel straight into a 4x4 buffer
// at DATA_W+2 bits. After row 3, one CALC cycle loads column 0 of the column
// transform into the output register; DRAIN then hands out columns 0..3 with
// backpressure. OUT_W must equal DATA_W+4.
module fft2d_4x4_stream
    import fft2d_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int OUT_W  = DATA_W + 4
) (
    input  logic                clk,
    input  logic                reset,
    fft2d_4x4_stream_if.slave   bus
);
    localparam int ROW_W = DATA_W + GROWTH_ROW;

    state_t                  state;
    logic [1:0]              row_cnt;
    logic                    inv_flag;
    logic                    load_ready;
    logic                    col_valid;
    logic                    col_last;
    logic [1:0]              col_idx;
    logic [N*OUT_W-1:0]      col_re;
    logic [N*OUT_W-1:0]      col_im;

    logic signed [ROW_W-1:0] buf_re [N][N];
    logic signed [ROW_W-1:0] buf_im [N][N];

    logic                    accept;
    logic                    row_inv;
    logic [N*ROW_W-1:0]      row_g_re, row_g_im;
    logic [1:0]              col_sel;
    logic [N*ROW_W-1:0]      col_in_re, col_in_im;
    logic [N*OUT_W-1:0]      col_g_re, col_g_im;

    assign accept  = bus.in_valid && load_ready;
    // Row 0 has not latched the mode yet, so it uses the live input.
    assign row_inv = (row_cnt == 2'd0) ? bus.in_inverse : inv_flag;

    // Row pass on the incoming beat.
    fft4_cplx_kernel #(.IN_W(DATA_W), .OUT_W(ROW_W)) row_pass (
        .a_re    (bus.in_re),
        .a_im    (bus.in_im),
        .inverse (row_inv),
        .g_re    (row_g_re),
        .g_im    (row_g_im)
    );

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int c = 0; c < N; c++) begin
                buf_re[row_cnt][c] <= row_g_re[lane_lo(c, ROW_W) +: ROW_W];
                buf_im[row_cnt][c] <= row_g_im[lane_lo(c, ROW_W) +: ROW_W];
            end
        end
    end

    // Column pass looks one column ahead of the one being presented, so the
    // next column is ready on the handshake edge.
    assign col_sel = (state == CALC) ? 2'd0 : col_idx + 2'd1;

    always_comb begin
        col_in_re = '0;
        col_in_im = '0;
        for (int r = 0; r < N; r++) begin
            col_in_re[lane_lo(r, ROW_W) +: ROW_W] = buf_re[r][col_sel];
            col_in_im[lane_lo(r, ROW_W) +: ROW_W] = buf_im[r][col_sel];
        end
    end

    fft4_cplx_kernel #(.IN_W(ROW_W), .OUT_W(OUT_W)) col_pass (
        .a_re    (col_in_re),
        .a_im    (col_in_im),
        .inverse (inv_flag),
        .g_re    (col_g_re),
        .g_im    (col_g_im)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= LOAD;
            row_cnt    <= 2'd0;
            inv_flag   <= 1'b0;
            load_ready <= 1'b1;
            col_valid  <= 1'b0;
            col_last   <= 1'b0;
            col_idx    <= 2'd0;
            col_re     <= '0;
            col_im     <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (accept) begin
                        row_cnt <= row_cnt + 2'd1;
                        if (row_cnt == 2'd0) inv_flag <= bus.in_inverse;
                        if (row_cnt == 2'd3) begin
                            state      <= CALC;
                            load_ready <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    col_re    <= col_g_re;
                    col_im    <= col_g_im;
                    col_idx   <= 2'd0;
                    col_last  <= 1'b0;
                    col_valid <= 1'b1;
                    state     <= DRAIN;
                end
                DRAIN: begin
                    if (bus.out_ready) begin
                        if (col_idx == 2'd3) begin
                            col_valid  <= 1'b0;
                            col_last   <= 1'b0;
                            load_ready <= 1'b1;
                            state      <= LOAD;
                        end else begin
                            col_re   <= col_g_re;
                            col_im   <= col_g_im;
                            col_idx  <= col_idx + 2'd1;
                            col_last <= (col_idx == 2'd2);
                        end
                    end
                end
                default: begin
                    state      <= LOAD;
                    load_ready <= 1'b1;
                    col_valid  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = load_ready;
    assign bus.out_valid = col_valid;
    assign bus.out_last  = col_last;
    assign bus.out_col   = col_idx;
    assign bus.out_re    = col_re;
    assign bus.out_im    = col_im;
endmodule

// File: tb/tb_fft2d_4x4_stream.sv
// Bench for fft2d_4x4_stream: directed frames plus $urandom data, checked
// against a direct 16-term DFT sum per output bin.
module tb_fft2d_4x4_stream;
    localparam int DATA_W = 16;
    localparam int OUT_W  = DATA_W + 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fft2d_4x4_stream_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    fft2d_4x4_stream #(.DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    longint xr [4][4];
    longint xi [4][4];
    longint mr [4][4];
    longint mi [4][4];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        checks++;
        assert (obs === expv) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // X[k][l] = sum x[r][c] * W^(rk+cl); W^e applied as a quarter-turn rotation.
    task automatic model(input bit inv);
        for (int k = 0; k < 4; k++) begin
            for (int l = 0; l < 4; l++) begin
                longint ar, ai;
                ar = 0;
                ai = 0;
                for (int r = 0; r < 4; r++) begin
                    for (int c = 0; c < 4; c++) begin
                        int e;
                        e = (r * k + c * l) % 4;
                        if (inv) e = (4 - e) % 4;
                        case (e)
                            0: begin ar += xr[r][c];  ai += xi[r][c];  end
                            1: begin ar += xi[r][c];  ai -= xr[r][c];  end
                            2: begin ar -= xr[r][c];  ai -= xi[r][c];  end
                            default: begin ar -= xi[r][c]; ai += xr[r][c]; end
                        endcase
                    end
                end
                mr[k][l] = ar;
                mi[k][l] = ai;
            end
        end
    endtask

    function automatic logic [4*OUT_W-1:0] pack_col(input int l, input bit im);
        logic [4*OUT_W-1:0] v;
        v = '0;
        for (int k = 0; k < 4; k++)
            v[k*OUT_W +: OUT_W] = im ? OUT_W'(mi[k][l]) : OUT_W'(mr[k][l]);
        return v;
    endfunction

    function automatic longint rnd_s();
        return longint'($urandom_range(65535, 0)) - 32768;
    endfunction

    task automatic fill(input longint vr, input longint vi);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                xr[r][c] = vr;
                xi[r][c] = vi;
            end
    endtask

    task automatic fill_rand();
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
                xr[r][c] = rnd_s();
                xi[r][c] = rnd_s();
            end
    endtask

    task automatic junk();
        bus.in_re      = {$urandom, $urandom};
        bus.in_im      = {$urandom, $urandom};
        bus.in_inverse = 1'($urandom);
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_in_ready"},  128'(bus.in_ready),  128'(1));
        chk({tag, "_out_valid"}, 128'(bus.out_valid), 128'(0));
        chk({tag, "_out_last"},  128'(bus.out_last),  128'(0));
        chk({tag, "_out_col"},   128'(bus.out_col),   128'(0));
        chk({tag, "_out_re"},    128'(bus.out_re),    128'(0));
        chk({tag, "_out_im"},    128'(bus.out_im),    128'(0));
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the last row's accept edge.
    task automatic send_rows(input int n, input bit inv, input bit toggle, input int gapmax);
        for (int r = 0; r < n; r++) begin
            int gaps;
            gaps = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            repeat (gaps) begin
                bus.in_valid = 1'b0;
                junk();
                @(negedge clk);
            end
            bus.in_valid = 1'b1;
            for (int c = 0; c < 4; c++) begin
                bus.in_re[c*DATA_W +: DATA_W] = DATA_W'(xr[r][c]);
                bus.in_im[c*DATA_W +: DATA_W] = DATA_W'(xi[r][c]);
            end
            bus.in_inverse = (r != 0 && toggle) ? ~inv : inv;
            chk("in_ready_load", 128'(bus.in_ready), 128'(1));
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    // Checks latency, then drains nbeats columns against the model.
    task automatic drain(input bit bp, input bit pulse, input int nbeats);
        int l, cyc;
        bit rdy;
        chk("calc_out_valid", 128'(bus.out_valid), 128'(0));
        chk("calc_in_ready",  128'(bus.in_ready),  128'(0));
        @(negedge clk);
        l = 0;
        cyc = 0;
        while (l < nbeats && cyc < 64) begin
            chk("out_valid",      128'(bus.out_valid), 128'(1));
            chk("out_col",        128'(bus.out_col),   128'(l));
            chk("out_last",       128'(bus.out_last),  128'(l == 3));
            chk("out_re",         128'(bus.out_re),    128'(pack_col(l, 1'b0)));
            chk("out_im",         128'(bus.out_im),    128'(pack_col(l, 1'b1)));
            chk("drain_in_ready", 128'(bus.in_ready),  128'(0));
            rdy = bp ? (cyc >= 5 && ((cyc - 5) % 2 == 0)) : 1'b1;
            bus.out_ready = rdy;
            if (pulse) begin
                bus.in_valid = 1'($urandom);
                junk();
            end
            @(negedge clk);
            if (rdy) l++;
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("beat_count", 128'(l), 128'(nbeats));
        if (nbeats == 4) begin
            chk("post_out_valid", 128'(bus.out_valid), 128'(0));
            chk("post_in_ready",  128'(bus.in_ready),  128'(1));
        end
    endtask

    task automatic run(input bit inv, input bit toggle, input int gapmax, input bit bp, input bit pulse);
        model(inv);
        send_rows(4, inv, toggle, gapmax);
        drain(bp, pulse, 4);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        reset          = 1'b1;
        bus.in_valid   = 1'b0;
        bus.in_re      = '0;
        bus.in_im      = '0;
        bus.in_inverse = 1'b0;
        bus.out_ready  = 1'b1;
        repeat (2) @(negedge clk);
        reset_vals("in_reset");
        reset = 1'b0;
        @(negedge clk);
        reset_vals("after_reset");

        // Impulse
        fill(0, 0);
        xr[0][0] = 1;
        run(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // DC, then full-scale negative DC on re, then on re and im in both modes
        fill(1, 0);
        run(1'b0, 1'b0, 0, 1'b0, 1'b0);
        fill(-32768, 0);
        run(1'b0, 1'b0, 0, 1'b0, 1'b0);
        fill(-32768, -32768);
        run(1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Single tone forward, inverse, inverse with mid-frame mode toggling
        fill(0, 0);
        xr[0][1] = 1;
        run(1'b0, 1'b0, 0, 1'b0, 1'b0);
        run(1'b1, 1'b0, 0, 1'b0, 1'b0);
        run(1'b1, 1'b1, 0, 1'b0, 1'b0);
        run(1'b0, 1'b1, 0, 1'b0, 1'b0);

        // Backpressure on random data
        fill_rand();
        run(1'b0, 1'b0, 0, 1'b1, 1'b0);
        fill_rand();
        run(1'b1, 1'b1, 0, 1'b1, 1'b1);

        // Input gaps and ignored in_valid pulses during drain
        for (int f = 0; f < 4; f++) begin
            fill_rand();
            run(1'($urandom), 1'b1, 3, 1'b0, 1'b1);
        end

        // Reset after row 2
        fill_rand();
        send_rows(3, 1'b1, 1'b0, 0);
        reset = 1'b1;
        #1;
        reset_vals("rst_load");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fill_rand();
        run(1'b0, 1'b0, 0, 1'b0, 1'b0);

        // Reset while column 1 is presented
        fill_rand();
        model(1'b1);
        send_rows(4, 1'b1, 1'b0, 0);
        drain(1'b0, 1'b0, 1);
        chk("pre_rst_col", 128'(bus.out_col), 128'(1));
        reset = 1'b1;
        #1;
        reset_vals("rst_drain");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        fill_rand();
        run(1'b1, 1'b0, 0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/fft2d_4x4_stream.md
# fft2d_4x4_stream

Streaming, parametrised 4x4 two-dimensional DFT engine that replaces the one-hot block-enable loader of the current 2D FFT data unit. It accepts one complex input row per valid/ready beat, computes the row 4-point DFT on entry, and after the fourth row emits the column transforms one column per beat with backpressure. Output width is full precision with no scaling or overflow. A per-frame forward/inverse mode is supported. It sits between the sample framer and the spectral post-processing stage.

## Interface
Parameters:
- DATA_W, 16, signed two's-complement input component width.
- OUT_W, DATA_W+4, output component width. Fixed at DATA_W+4; other values are illegal.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-high.
- in_valid  in  1  input row beat valid.
- in_ready  out  1  engine can accept a row.
- in_re, in_im  in  4*DATA_W  row samples; lane i at [i*DATA_W +: DATA_W] is column i.
- in_inverse  in  1  mode; sampled only on the row-0 accept.
- out_valid  out  1  output column beat valid.
- out_ready  in  1  downstream accepts the column.
- out_re, out_im  out  4*OUT_W  column result; lane k at [k*OUT_W +: OUT_W] is X[k][out_col].
- out_col  out  2  column index of the current beat.
- out_last  out  1  high with column 3.

## Operation
- Convention: x[r][c], with r the row (beat number) and c the lane.
- Forward transform: X[k][l] = sum over r,c of x[r][c]·W^(rk+cl), with W = e^(-j2π/4).
- Inverse mode replaces W with e^(+j2π/4). No 1/16 scaling is applied.
- 4-point kernel, applied to inputs a0..a3:
  - G0 = a0+a1+a2+a3.
  - G2 = a0-a1+a2-a3.
  - G1 = (a0-a2) - s·j·(a1-a3).
  - G3 = (a0-a2) + s·j·(a1-a3).
  - s = +1 for forward, -1 for inverse.
  - j·(x+jy) = -y+jx is a swap plus negate only; the kernel has no multipliers.
- Width growth:
  - Row pass sign-extends inputs, and its results are stored at DATA_W+2.
  - Column pass sign-extends to OUT_W.
  - Both passes are exact, with no wrap for any input, including all lanes at -2^(DATA_W-1).
- Buffer: one 4x4 complex array at DATA_W+2. Row r's kernel output is written to buffer[r][0..3] on its accept edge.
- Row counter: 2 bits, incremented on each accept and wrapping 3->0.
- FSM:
  - LOAD: in_ready=1, out_valid=0. The row-3 accept moves to CALC.
  - CALC: in_ready=0, one cycle. The output register loads column 0 through the column kernel, out_valid goes to 1, and the state moves to DRAIN.
  - DRAIN: in_ready=0.
    - On a handshake with out_col<3, the register loads column out_col+1 on the same edge, so out_valid stays high.
    - On the handshake with out_col=3, out_valid goes to 0 and the state returns to LOAD.
- Mode latching: the inverse flag is latched on the row-0 accept and used for both passes of that frame. Changes to in_inverse during a frame are ignored.
- Row-pass mode: the row pass for row 0 uses the live in_inverse value on its accept edge.
- in_valid outside LOAD is ignored; no row is consumed.

## Timing
- Reset values:
  - State = LOAD, row counter = 0, inverse flag = 0.
  - in_ready = 1 from reset deassertion.
  - out_valid = 0, out_last = 0, out_col = 0, out_re = 0, out_im = 0.
- Reset mid-frame, in any state: partial rows and pending columns are discarded, with no output beat. The next frame starts with row 0.
- Latency: if row 3 is accepted at edge E, out_valid=1 and column 0 are present after edge E+1.
- Throughput: minimum frame period is 4 + 1 + 4 = 9 cycles with out_ready held high. There is no overlap of load and drain.
- Handshake rules:
  - A transfer occurs when valid and ready are both high at an edge.
  - While out_valid=1 and out_ready=0, out_re, out_im, out_col and out_last hold stable.
  - in_ready does not depend combinationally on in_valid.
  - out_valid does not depend combinationally on out_ready.
- in_ready returns to 1 in the cycle after the out_last handshake.

## Structure
- Package fft2d_pkg holds:
  - localparams N=4 and GROWTH_ROW=2.
  - The state enum {LOAD, CALC, DRAIN}.
  - Lane-slice helper functions.
- Sub-module fft4_cplx_kernel: a combinational, width-parameterised complex 4-point kernel with an inverse input.
  - One instance is used for the row pass on the input.
  - One instance is used for the column pass on the buffer column selected by the column counter.

## Test plan
- Impulse: x[0][0]=1+0j, all other samples 0, forward -> all 16 outputs are 1+0j. Columns arrive with out_col 0,1,2,3 and out_last on the fourth beat.
- DC: all samples 1+0j -> X[0][0]=16, the other 15 outputs 0. Repeat with all re=-32768 -> X[0][0]=-524288, no wrap.
- Single tone: x[0][1]=1, forward -> column 0 lanes are 1, column 1 lanes are -j, column 2 lanes are -1, column 3 lanes are +j. The same input with in_inverse=1 -> column 1 is +j and column 3 is -j. Toggling in_inverse mid-frame has no effect.
- Backpressure: hold out_ready=0 for 5 cycles on column 0, then toggle it every cycle. Outputs stay stable while stalled, exactly 4 beats are emitted, and in_ready=0 until the out_last handshake.
- Input gaps: drop in_valid between rows for random 0-3 cycles -> results are identical to the gapless case. in_valid pulses during DRAIN are not consumed.
- Reset mid-operation: assert reset after row 2, then again during the column-1 beat -> outputs go to reset values immediately, and the next full frame produces correct results.
